// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and types for the SPI target
package spi_pkg;
    localparam int SPI_MODE = 0;
    typedef logic [7:0] spi_byte_t;
    localparam spi_byte_t IDLE_BYTE_DEF = 8'hFF;
    typedef enum logic {IDLE, ACTIVE} spi_tgt_state_t;
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: synchroniser chain plus edge detect for one SPI pin
// pin_i asynchronous input; level_o synced level; rise_o/fall_o one-cycle edge strobes
module spi_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end
    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o && !prev_q;
    assign fall_o  = !level_o && prev_q;
endmodule

// File: rtl/spi_target.sv
// spi_target: SPI mode-0 responder oversampling the pins on clk
// sclk/ssel/mosi: SPI pins in; miso/miso_oe: SPI data out and frame-active enable
// rx_data/rx_valid/rx_first: received bytes; tx_data/tx_valid/tx_ready: byte to send
// tx_underrun: IDLE_BYTE loaded from an empty holding register; frame_end: ssel deasserted
module spi_target
    import spi_pkg::*;
#(
    parameter int        SYNC_STAGES = 2,
    parameter spi_byte_t IDLE_BYTE   = IDLE_BYTE_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      sclk,
    input  logic      ssel,
    input  logic      mosi,
    output logic      miso,
    output logic      miso_oe,
    output spi_byte_t rx_data,
    output logic      rx_valid,
    output logic      rx_first,
    input  spi_byte_t tx_data,
    input  logic      tx_valid,
    output logic      tx_ready,
    output logic      tx_underrun,
    output logic      frame_end
);
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic ssel_lvl, ssel_rise, ssel_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic unused;
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .pin_i(sclk), .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ssel (
        .clk(clk), .rst_n(rst_n), .pin_i(ssel), .level_o(ssel_lvl), .rise_o(ssel_rise), .fall_o(ssel_fall)
    );
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst_n(rst_n), .pin_i(mosi), .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );
    assign unused = ^{sclk_lvl, ssel_lvl, mosi_rise, mosi_fall};
    spi_tgt_state_t state_q;
    logic [2:0]     bit_cnt_q;
    logic           first_q, hold_full_q;
    spi_byte_t      rx_shift_q, tx_shift_q, hold_q, rx_data_q;
    logic           rx_valid_q, rx_first_q, tx_underrun_q, frame_end_q, miso_q, miso_oe_q;
    logic           wr_d, load_d;
    spi_byte_t      load_byte_d;
    // A load happens at frame start and at every byte boundary fall; a write
    // coinciding with a load into an empty register bypasses straight to tx_shift.
    always_comb begin
        wr_d        = tx_valid && !hold_full_q;
        load_d      = (state_q == IDLE) ? ssel_fall : (sclk_fall && !ssel_rise && bit_cnt_q == 3'd0);
        load_byte_d = hold_full_q ? hold_q : wr_d ? tx_data : IDLE_BYTE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= 3'd0;
            first_q       <= 1'b0;
            hold_full_q   <= 1'b0;
            hold_q        <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_first_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_end_q   <= 1'b0;
            miso_q        <= 1'b1;
            miso_oe_q     <= 1'b0;
        end else begin
            rx_valid_q    <= 1'b0;
            rx_first_q    <= 1'b0;
            frame_end_q   <= 1'b0;
            tx_underrun_q <= load_d && !hold_full_q && !wr_d;
            if (load_d) begin
                hold_full_q <= 1'b0;
                tx_shift_q  <= load_byte_d;
                miso_q      <= load_byte_d[7];
            end else if (wr_d) begin
                hold_q      <= tx_data;
                hold_full_q <= 1'b1;
            end
            if (state_q == IDLE) begin
                if (ssel_fall) begin
                    state_q   <= ACTIVE;
                    bit_cnt_q <= 3'd0;
                    first_q   <= 1'b1;
                    miso_oe_q <= 1'b1;
                end
            end else begin
                if (sclk_rise) begin
                    rx_shift_q <= {rx_shift_q[6:0], mosi_lvl};
                    bit_cnt_q  <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_q  <= {rx_shift_q[6:0], mosi_lvl};
                        rx_valid_q <= 1'b1;
                        rx_first_q <= first_q;
                        first_q    <= 1'b0;
                    end
                end
                if (sclk_fall && bit_cnt_q != 3'd0) begin
                    tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                    miso_q     <= tx_shift_q[6];
                end
                // Frame end wins over any bit activity, but a byte completing
                // in the same cycle has already been posted above.
                if (ssel_rise) begin
                    state_q     <= IDLE;
                    bit_cnt_q   <= 3'd0;
                    frame_end_q <= 1'b1;
                    miso_oe_q   <= 1'b0;
                    miso_q      <= 1'b1;
                end
            end
        end
    end
    assign miso        = miso_q;
    assign miso_oe     = miso_oe_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_first    = rx_first_q;
    assign tx_ready    = !hold_full_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_end   = frame_end_q;
endmodule
